// File: rtl/scfifo_stream_reader.sv
// scfifo_stream_reader: drains a single-clock FIFO into a valid/ready
// stream through a small in-order skid buffer with registered outputs.
module scfifo_stream_reader #(
    parameter int    DWIDTH    = 8,
    parameter string SHOWAHEAD = "ON",
    parameter int    CWIDTH    = 16
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              empty_i,
    input  logic [DWIDTH-1:0] q_i,
    output logic              rdreq_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CWIDTH-1:0] cnt_o
);

    // Non-showahead FIFOs return q one cycle late, so one extra slot
    // absorbs the word that is still in flight when the consumer stalls.
    localparam bit OFF   = (SHOWAHEAD != "ON");
    localparam int DEPTH = OFF ? 3 : 2;

    logic [DWIDTH-1:0] mem [3];
    logic [1:0]        occ;
    logic [1:0]        occ_nxt;
    logic              inflight;
    logic              cap;
    logic              pop;
    logic [1:0]        wr_idx;
    logic [2:0]        level;

    // Read issue, capture and pop decisions; rdreq ignores ready on purpose.
    always_comb begin
        level   = {1'b0, occ} + {2'b0, inflight};
        rdreq_o = !srst_i && !empty_i && (level < 3'(DEPTH));
        cap     = OFF ? inflight : rdreq_o;
        pop     = valid_o && ready_i;
        wr_idx  = occ - {1'b0, pop};
        occ_nxt = occ + {1'b0, cap} - {1'b0, pop};
    end

    assign data_o = mem[0];

    // Buffer shift/write, occupancy, in-flight flag and transfer counter.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            mem[2]   <= '0;
            occ      <= '0;
            inflight <= 1'b0;
            valid_o  <= 1'b0;
            cnt_o    <= '0;
        end else begin
            if (pop) begin
                mem[0] <= mem[1];
                mem[1] <= mem[2];
            end
            if (cap) begin
                mem[wr_idx] <= q_i;
            end
            occ      <= occ_nxt;
            valid_o  <= (occ_nxt != 2'd0);
            inflight <= OFF && rdreq_o;
            if (pop) begin
                cnt_o <= cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scfifo_stream_reader.sv
// tb_scfifo_stream_reader: three reader instances (ON, OFF, ON with a
// 4-bit counter) fed by queue-based FIFO models and a scoreboard monitor.
module tb_scfifo_stream_reader;

    localparam logic [2:0] OFFM = 3'b010;

    logic             clk = 1'b0;
    logic [2:0]       srst = 3'b111;
    logic [2:0]       ready = 3'b000;
    logic [2:0]       empty = 3'b111;
    logic [2:0][7:0]  q = '0;
    wire  [2:0]       rdreq;
    wire  [2:0]       valid;
    wire  [2:0][7:0]  data;
    wire  [15:0]      cnt0;
    wire  [15:0]      cnt1;
    wire  [3:0]       cnt2;

    logic [7:0] fq [3][$];
    logic [7:0] exp_q [3][$];
    logic [7:0] qreg [3] = '{8'h0, 8'h0, 8'h0};
    logic [2:0] wr_en = 3'b000;
    logic [7:0] wd [3] = '{8'h0, 8'h0, 8'h0};
    logic [2:0] pre_rd = '0;
    logic [2:0] pre_v = '0;
    logic [7:0] pre_d [3] = '{8'h0, 8'h0, 8'h0};

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    scfifo_stream_reader #(.DWIDTH(8), .SHOWAHEAD("ON"), .CWIDTH(16)) dut0 (
        .clk_i(clk), .srst_i(srst[0]), .empty_i(empty[0]), .q_i(q[0]),
        .rdreq_o(rdreq[0]), .data_o(data[0]), .valid_o(valid[0]),
        .ready_i(ready[0]), .cnt_o(cnt0));

    scfifo_stream_reader #(.DWIDTH(8), .SHOWAHEAD("OFF"), .CWIDTH(16)) dut1 (
        .clk_i(clk), .srst_i(srst[1]), .empty_i(empty[1]), .q_i(q[1]),
        .rdreq_o(rdreq[1]), .data_o(data[1]), .valid_o(valid[1]),
        .ready_i(ready[1]), .cnt_o(cnt1));

    scfifo_stream_reader #(.DWIDTH(8), .SHOWAHEAD("ON"), .CWIDTH(4)) dut2 (
        .clk_i(clk), .srst_i(srst[2]), .empty_i(empty[2]), .q_i(q[2]),
        .rdreq_o(rdreq[2]), .data_o(data[2]), .valid_o(valid[2]),
        .ready_i(ready[2]), .cnt_o(cnt2));

    function automatic logic [31:0] getcnt(int k);
        case (k)
            0:       return {16'b0, cnt0};
            1:       return {16'b0, cnt1};
            default: return {28'b0, cnt2};
        endcase
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        nchk++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h at %0t", nm, act, want, $time);
        end
    endtask

    // One clock: sample just before the edge, then update the FIFO models.
    task automatic tick();
        #4;
        pre_rd = rdreq;
        pre_v  = valid;
        for (int k = 0; k < 3; k++) pre_d[k] = data[k];
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (srst[k]) begin
                fq[k].delete();
                exp_q[k].delete();
                qreg[k] = 8'h0;
            end else begin
                if (pre_rd[k] && fq[k].size() != 0) begin
                    if (OFFM[k]) qreg[k] = fq[k].pop_front();
                    else void'(fq[k].pop_front());
                end
                if (wr_en[k]) begin
                    fq[k].push_back(wd[k]);
                    exp_q[k].push_back(wd[k]);
                end
            end
            empty[k] = (fq[k].size() == 0);
            if (OFFM[k]) q[k] = qreg[k];
            else q[k] = (fq[k].size() != 0) ? fq[k][0] : 8'h0;
        end
        @(negedge clk);
    endtask

    // Scoreboard monitor: checks every accepted word and the hold rule.
    initial begin : monitor
        logic [2:0] pv;
        logic [2:0] pr;
        logic [2:0] ps;
        logic [7:0] pd [3];
        int         xc [3];
        logic [31:0] mask;
        pv = '0;
        pr = '0;
        ps = '1;
        for (int k = 0; k < 3; k++) begin
            pd[k] = '0;
            xc[k] = 0;
        end
        forever begin
            @(negedge clk);
            #4;
            for (int k = 0; k < 3; k++) begin
                mask = (k == 2) ? 32'hF : 32'hFFFF;
                chk("rdreq_while_empty", {31'b0, rdreq[k] & empty[k]}, 32'd0);
                if (srst[k]) begin
                    xc[k] = 0;
                end else begin
                    if (pv[k] && !pr[k] && !ps[k]) begin
                        chk("hold_valid", {31'b0, valid[k]}, 32'd1);
                        chk("hold_data", {24'b0, data[k]}, {24'b0, pd[k]});
                    end
                    if (valid[k] && ready[k]) begin
                        chk("cnt_before_xfer", getcnt(k), 32'(xc[k]) & mask);
                        if (exp_q[k].size() == 0) begin
                            nchk++;
                            nerr++;
                            $display("FAIL unexpected_word: got %0h, want none (dut%0d)",
                                     data[k], k);
                        end else begin
                            chk("word_order", {24'b0, data[k]},
                                {24'b0, exp_q[k].pop_front()});
                        end
                        xc[k]++;
                    end
                end
                pv[k] = valid[k];
                pr[k] = ready[k];
                ps[k] = srst[k];
                pd[k] = data[k];
            end
        end
    end

    initial begin : stim
        int n;
        logic seen_wrap;
        logic [3:0] pc;
        @(negedge clk);
        // Power-on reset
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", {31'b0, valid[k]}, 32'd0);
            chk("rst_cnt", getcnt(k), 32'd0);
            chk("rst_data", {24'b0, data[k]}, 32'd0);
            chk("rst_rdreq", {31'b0, pre_rd[k]}, 32'd0);
        end
        srst = 3'b000;

        // Reset with five words sitting in the FIFO
        wr_en[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wd[0] = 8'(8'h70 + i);
            tick();
        end
        wr_en[0] = 1'b0;
        srst[0] = 1'b1;
        tick();
        chk("rst5_rdreq_a", {31'b0, pre_rd[0]}, 32'd0);
        tick();
        chk("rst5_rdreq_b", {31'b0, pre_rd[0]}, 32'd0);
        srst[0] = 1'b0;
        chk("rst5_valid", {31'b0, valid[0]}, 32'd0);
        chk("rst5_cnt", {16'b0, cnt0}, 32'd0);

        // ON streaming 0x01..0x10
        ready[0] = 1'b1;
        wr_en[0] = 1'b1;
        wd[0] = 8'h01;
        tick();
        chk("on_rdreq_at_n", {31'b0, rdreq[0]}, 32'd1);
        chk("on_valid_at_n", {31'b0, valid[0]}, 32'd0);
        for (int i = 1; i <= 16; i++) begin
            wr_en[0] = (i < 16);
            wd[0] = 8'(i + 1);
            tick();
            chk("on_stream_valid", {31'b0, valid[0]}, 32'd1);
            chk("on_stream_data", {24'b0, data[0]}, 32'(i));
        end
        wr_en[0] = 1'b0;
        tick();
        chk("on_stream_cnt", {16'b0, cnt0}, 32'd16);
        chk("on_stream_idle", {31'b0, valid[0]}, 32'd0);
        ready[0] = 1'b0;

        // OFF backpressure 0xA0..0xAF
        n = 0;
        for (int i = 0; i < 26; i++) begin
            ready[1] = (i >= 10);
            wr_en[1] = (i < 16);
            wd[1] = 8'(8'hA0 + i);
            tick();
            if (i == 0) chk("off_rdreq_at_n", {31'b0, rdreq[1]}, 32'd1);
            if (i == 1) chk("off_valid_n1", {31'b0, valid[1]}, 32'd0);
            if (i == 2) chk("off_valid_n2", {31'b0, valid[1]}, 32'd1);
            if (i < 10) n += int'(pre_rd[1]);
            if (i == 9) chk("off_stall_data", {24'b0, data[1]}, 32'hA0);
            if (i == 11) chk("off_resume_rdreq", {31'b0, pre_rd[1]}, 32'd1);
            if (i >= 10) begin
                chk("off_xfer_valid", {31'b0, pre_v[1]}, 32'd1);
                chk("off_xfer_data", {24'b0, pre_d[1]}, 32'(8'hA0 + i - 10));
            end
        end
        chk("off_stall_pulses", 32'(n), 32'd3);
        wr_en[1] = 1'b0;
        ready[1] = 1'b0;
        tick();

        // Counter wrap with a 4-bit counter
        ready[2] = 1'b1;
        seen_wrap = 1'b0;
        pc = cnt2;
        for (int i = 0; i < 20; i++) begin
            wr_en[2] = (i < 17);
            wd[2] = 8'(8'h40 + i);
            tick();
            if (pc == 4'hF && cnt2 != 4'hF) begin
                chk("wrap_15_to_0", {28'b0, cnt2}, 32'd0);
                seen_wrap = 1'b1;
            end
            pc = cnt2;
        end
        chk("wrap_seen", {31'b0, seen_wrap}, 32'd1);
        chk("wrap_final", {28'b0, cnt2}, 32'd1);
        wr_en[2] = 1'b0;
        ready[2] = 1'b0;

        // Random ready and writes, both modes
        for (int c = 0; c < 2048; c++) begin
            for (int k = 0; k < 2; k++) begin
                ready[k] = 1'($urandom_range(0, 1));
                wr_en[k] = 1'($urandom_range(0, 1));
                wd[k] = 8'($urandom);
            end
            tick();
        end
        wr_en = 3'b000;
        ready = 3'b011;
        n = 0;
        while (n < 4000 && (exp_q[0].size() != 0 || exp_q[1].size() != 0)) begin
            tick();
            n++;
        end
        chk("rand_drain_on", 32'(exp_q[0].size()), 32'd0);
        chk("rand_drain_off", 32'(exp_q[1].size()), 32'd0);
        tick();
        ready = 3'b000;

        // Reset mid-stream in OFF mode: occ=2, inflight=1
        for (int i = 0; i < 4; i++) begin
            wr_en[1] = 1'b1;
            wd[1] = 8'(8'h30 + i);
            tick();
        end
        wr_en[1] = 1'b0;
        srst[1] = 1'b1;
        tick();
        srst[1] = 1'b0;
        chk("mid_rst_valid", {31'b0, valid[1]}, 32'd0);
        wr_en[1] = 1'b1;
        wd[1] = 8'h5A;
        ready[1] = 1'b1;
        tick();
        wr_en[1] = 1'b0;
        n = 0;
        while (n < 10 && !valid[1]) begin
            tick();
            n++;
        end
        chk("mid_rst_first_valid", {31'b0, valid[1]}, 32'd1);
        chk("mid_rst_first_word", {24'b0, data[1]}, 32'h5A);
        tick();
        tick();
        ready[1] = 1'b0;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
